ram_uploader: RTL and testbench

//  Reads a contiguous address range from the shared Apple-1 memory bus and streams it out one byte at a time.

---
 rtl/ram_uploader.sv | 200 ++++++++++++++++++++
 tb/tb_ram_uploader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_uploader.sv
// ram_uploader: reads the inclusive range [start_addr, end_addr] from the shared
// memory bus, one byte per bus slot, and streams it out over a valid/ready
// byte handshake. Each read waits for a clk_ena slot and then RD_LATENCY
// cycles for the data; there is no prefetch.
// Optional feature: define UPLOAD_CHECKSUM_EN to append an 8-bit sum (mod 256)
// of the data bytes as the final stream byte.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; range check and address latch
// READ    | waiting for a clk_ena slot; mem_rd pulses in that slot
// WAIT    | counting down the memory read latency, then capture mem_din
// PRESENT | byte on out_data with out_valid=1 until out_ready
// CSUM    | checksum byte presented as final byte (UPLOAD_CHECKSUM_EN)
// DONE    | one-cycle done pulse, then back to IDLE

module ram_uploader #(
    parameter int ADDR_WIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  sys_clock_i,
    input  logic                  reset_n_i,
    input  logic                  clk_ena_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic [ADDR_WIDTH-1:0] end_addr_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_rd_o,
    input  logic [7:0]            mem_din_i,
    output logic [7:0]            out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_last_o
);

    // Counter reload so that capture happens exactly RD_LATENCY cycles after mem_rd.
    localparam logic [1:0] LAT_LOAD = 2'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_PRESENT,
`ifdef UPLOAD_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] end_q;
    logic [1:0]            lat_cnt_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    logic [7:0]            data_q;
    logic                  valid_q;
    logic                  last_q;

    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  at_end;
    logic                  xfer;
    logic                  last_data;

`ifdef UPLOAD_CHECKSUM_EN
    logic [7:0] csum_q;
    logic [7:0] csum_d;
    assign csum_d    = csum_q + mem_din_i;
    // The checksum byte carries out_last, never a data byte.
    assign last_data = 1'b0;
`else
    assign last_data = at_end;
`endif

    // End test uses the pre-increment address so an all-ones end never wraps.
    assign at_end = (addr_q == end_q);
    assign addr_d = addr_q + ADDR_WIDTH'(1);
    assign xfer   = valid_q & out_ready_i;

    // The strobe is gated by the slot enable so the read lands in the granted bus slot.
    assign mem_rd_o    = (state_q == S_READ) & clk_ena_i;
    assign mem_addr_o  = addr_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;
    assign out_last_o  = last_q;

    // Upload sequencer with registered status and stream outputs.
    always_ff @(posedge sys_clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            end_q     <= '0;
            lat_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            if (abort_i && (state_q != S_IDLE)) begin
                // Abort wins over a same-cycle transfer; the pending byte is dropped.
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            if (end_addr_i >= start_addr_i) begin
                                addr_q  <= start_addr_i;
                                end_q   <= end_addr_i;
                                busy_q  <= 1'b1;
                                state_q <= S_READ;
`ifdef UPLOAD_CHECKSUM_EN
                                csum_q  <= '0;
`endif
                            end else begin
                                error_q <= 1'b1;
                            end
                        end
                    end
                    S_READ: begin
                        if (clk_ena_i) begin
                            lat_cnt_q <= LAT_LOAD;
                            state_q   <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (lat_cnt_q == 2'd0) begin
                            data_q  <= mem_din_i;
                            valid_q <= 1'b1;
                            last_q  <= last_data;
                            state_q <= S_PRESENT;
`ifdef UPLOAD_CHECKSUM_EN
                            csum_q  <= csum_d;
`endif
                        end else begin
                            lat_cnt_q <= lat_cnt_q - 2'd1;
                        end
                    end
                    S_PRESENT: begin
                        if (xfer) begin
                            if (at_end) begin
`ifdef UPLOAD_CHECKSUM_EN
                                data_q  <= csum_q;
                                last_q  <= 1'b1;
                                state_q <= S_CSUM;
`else
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
`endif
                            end else begin
                                addr_q  <= addr_d;
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                                state_q <= S_READ;
                            end
                        end
                    end
`ifdef UPLOAD_CHECKSUM_EN
                    S_CSUM: begin
                        if (xfer) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
`endif
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ram_uploader.sv
// Bench for ram_uploader: behavioural memory with one-cycle read latency,
// slot-enable and ready generators, and a byte scoreboard fed at start.
module tb_ram_uploader;

`ifdef UPLOAD_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_ena;
    logic        start;
    logic        abort;
    logic [15:0] start_addr;
    logic [15:0] end_addr;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_din;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    ram_uploader #(.ADDR_WIDTH(16), .RD_LATENCY(1)) dut (
        .sys_clock_i (clk),
        .reset_n_i   (reset_n),
        .clk_ena_i   (clk_ena),
        .start_i     (start),
        .abort_i     (abort),
        .start_addr_i(start_addr),
        .end_addr_i  (end_addr),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (error),
        .mem_addr_o  (mem_addr),
        .mem_rd_o    (mem_rd),
        .mem_din_i   (mem_din),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_last_o  (out_last)
    );

    always #5 clk = ~clk;

    // Memory: data valid the cycle after the read strobe.
    logic [7:0] mem [0:65535];
    logic [7:0] rd_q = 8'h00;
    always @(posedge clk) if (mem_rd) rd_q <= mem[mem_addr];
    assign mem_din = rd_q;

    // Slot enable: one cycle in every ena_period.
    int ena_period = 1;
    int ena_cnt = 0;
    always @(posedge clk) begin
        #1;
        ena_cnt = (ena_cnt + 1 >= ena_period) ? 0 : ena_cnt + 1;
        clk_ena = (ena_cnt == 0);
    end

    // Consumer ready: forced level or random.
    bit   ready_rand = 1'b0;
    logic ready_val = 1'b1;
    always @(posedge clk) begin
        #1;
        out_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
    end

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;
    exp_t sb[$];
    exp_t e_pop;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    int   done_cnt, err_cnt, rd_cnt, xfer_cnt;
    bit   busy_seen, watch_wrap;
    logic prev_rd = 1'b0;

    // Monitor: strobe spacing, wrap guard, pulse counts, scoreboard pops.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (mem_rd) begin
                rd_cnt++;
                check("rd_gap", 32'(prev_rd), 32'(0));
                if (watch_wrap) check("no_wrap", 32'(mem_addr == 16'h0000), 32'(0));
            end
            prev_rd = mem_rd;
            if (done)  done_cnt++;
            if (error) err_cnt++;
            if (busy)  busy_seen = 1'b1;
            if (out_valid && out_ready) begin
                xfer_cnt++;
                if (sb.size() == 0) begin
                    check("sb_extra", 32'(1), 32'(0));
                end else begin
                    e_pop = sb.pop_front();
                    check("data", 32'(out_data), 32'(e_pop.data));
                    check("last", 32'(out_last), 32'(e_pop.last));
                end
            end
        end else begin
            prev_rd = 1'b0;
        end
    end

    task automatic clr_counts();
        done_cnt = 0; err_cnt = 0; rd_cnt = 0; xfer_cnt = 0;
        busy_seen = 1'b0; watch_wrap = 1'b0;
        sb.delete();
    endtask

    task automatic push_expected(input logic [15:0] s, input logic [15:0] e);
        logic [7:0] sum;
        exp_t x;
        sum = 8'h00;
        for (int a = int'(s); a <= int'(e); a++) begin
            x.data = mem[a[15:0]];
            x.last = (a == int'(e)) && !CSUM;
            sum    = sum + x.data;
            sb.push_back(x);
        end
        if (CSUM) begin
            x.data = sum;
            x.last = 1'b1;
            sb.push_back(x);
        end
    endtask

    task automatic kick(input logic [15:0] s, input logic [15:0] e);
        @(posedge clk); #1;
        start_addr = s; end_addr = e; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("done_count", 32'(done_cnt), 32'(1));
        check("busy_after", 32'(busy), 32'(0));
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !out_valid; i++) begin
            @(negedge clk); #1;
        end
        check("valid_seen", 32'(out_valid), 32'(1));
    endtask

    typedef struct {
        logic [15:0] s;
        logic [15:0] e;
        int          period;
        bit          rnd;
        bit          exp_err;
        int          nbytes;
    } vec_t;
    vec_t vecs[6];

    logic [7:0] held;
    int         r0;

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h0300, 16'h0303, 7, 1'b0, 1'b0, 4};
        vecs[1] = '{16'h0280, 16'h027F, 1, 1'b0, 1'b1, 0};
        vecs[2] = '{16'h1000, 16'h1000, 1, 1'b0, 1'b0, 1};
        vecs[3] = '{16'hFFFE, 16'hFFFF, 3, 1'b0, 1'b0, 2};
        vecs[4] = '{16'h2000, 16'h2007, 1, 1'b1, 1'b0, 8};
        vecs[5] = '{16'h0700, 16'h0702, 2, 1'b1, 1'b0, 3};

        for (int a = 0; a < 65536; a++) mem[a] = 8'(a * 7 + 3) ^ 8'(a >> 8);
        mem[16'h0300] = 8'h11; mem[16'h0301] = 8'h22;
        mem[16'h0302] = 8'h33; mem[16'h0303] = 8'h44;
        mem[16'h0700] = 8'h80; mem[16'h0701] = 8'h90; mem[16'h0702] = 8'hA0;

        reset_n = 1'b0; clk_ena = 1'b0; start = 1'b0; abort = 1'b0;
        start_addr = 16'h0; end_addr = 16'h0;
        clr_counts();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", 32'({busy, done, error, mem_rd, out_valid, out_last, out_data, mem_addr}), 32'(0));
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Table-driven uploads and rejected ranges.
        for (int v = 0; v < 6; v++) begin
            clr_counts();
            ena_period = vecs[v].period;
            ready_rand = vecs[v].rnd;
            ready_val  = 1'b1;
            watch_wrap = (vecs[v].e == 16'hFFFF);
            if (!vecs[v].exp_err) push_expected(vecs[v].s, vecs[v].e);
            kick(vecs[v].s, vecs[v].e);
            if (vecs[v].exp_err) begin
                repeat (4) @(posedge clk);
                #1;
                check("err_pulse", 32'(err_cnt), 32'(1));
                check("err_busy", 32'(busy_seen), 32'(0));
                check("err_no_rd", 32'(rd_cnt), 32'(0));
            end else begin
                wait_done(3000);
                check("xfer_count", 32'(xfer_cnt), 32'(vecs[v].nbytes + int'(CSUM)));
                check("sb_empty", 32'(sb.size()), 32'(0));
                check("no_err", 32'(err_cnt), 32'(0));
            end
        end
        ready_rand = 1'b0;
        ena_period = 1;

        // Back-pressure: byte held stable, no further reads until released.
        clr_counts();
        ready_val = 1'b0;
        push_expected(16'h0400, 16'h0402);
        kick(16'h0400, 16'h0402);
        wait_valid(50);
        held = out_data;
        r0   = rd_cnt;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            check("stall_valid", 32'(out_valid), 32'(1));
            check("stall_data", 32'(out_data), 32'(held));
        end
        check("stall_no_rd", 32'(rd_cnt), 32'(r0));
        ready_val = 1'b1;
        wait_done(500);
        check("stall_rd_total", 32'(rd_cnt), 32'(3));

        // Abort while waiting for the third byte's read data.
        clr_counts();
        push_expected(16'h0500, 16'h0507);
        kick(16'h0500, 16'h0507);
        for (int i = 0; i < 200 && rd_cnt < 3; i++) begin
            @(negedge clk); #1;
        end
        check("abort_reach", 32'(rd_cnt), 32'(3));
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_valid", 32'(out_valid), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt), 32'(0));
        check("abort_xfers", 32'(xfer_cnt), 32'(2));
        check("abort_rds", 32'(rd_cnt), 32'(3));

        // Fresh upload accepted after abort.
        clr_counts();
        push_expected(16'h0300, 16'h0303);
        kick(16'h0300, 16'h0303);
        wait_done(500);
        check("post_abort_xfers", 32'(xfer_cnt), 32'(4 + int'(CSUM)));

        // Asynchronous reset while a byte is presented.
        clr_counts();
        ready_val = 1'b0;
        push_expected(16'h0600, 16'h0602);
        kick(16'h0600, 16'h0602);
        wait_valid(50);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_reset", 32'({busy, done, error, mem_rd, out_valid, out_last, out_data, mem_addr}), 32'(0));
        @(posedge clk); #1;
        reset_n = 1'b1;
        ready_val = 1'b1;
        clr_counts();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
